// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the EX/MEM payload, runs one load/store at a time
// on the data RAM through a req/addr_ok/data_ok handshake, and forwards results to WB.
module mem_stage #(
    parameter int EM_BUS_WD = 113,
    parameter int MW_BUS_WD = 111,
    parameter int BY_BUS_WD = 40
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 EX_to_MEM_valid,
    output logic                 MEM_allow_in,
    input  logic [EM_BUS_WD-1:0] EX_to_MEM_bus,
    output logic                 MEM_to_WB_valid,
    input  logic                 WB_allow_in,
    output logic [MW_BUS_WD-1:0] MEM_to_WB_bus,
    output logic [BY_BUS_WD-1:0] MEM_to_BY_bus,
    output logic                 data_ram_req,
    output logic                 data_ram_wr,
    output logic [3:0]           data_ram_wstrb,
    output logic [31:0]          data_ram_addr,
    output logic [31:0]          data_ram_wdata,
    input  logic                 data_ram_addr_ok,
    input  logic                 data_ram_data_ok,
    input  logic [31:0]          data_ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_mem_valid;
    logic [EM_BUS_WD-1:0]   r_em_bus;
    logic [31:0]            r_rdata_buf;

    logic [2:0]  w_stage;
    logic        w_rf_we;
    logic        w_sel_rf_wdata;
    logic        w_sel_ram_wd;
    logic        w_ram_rd;
    logic        w_ram_wr;
    logic [3:0]  w_ram_ben;
    logic [31:0] w_ram_wdata;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic        w_memop;
    logic        w_in_memop;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_next_memop;
    logic        w_data_valid;
    logic [31:0] w_wb_rdata;

    assign {w_stage, w_rf_we, w_sel_rf_wdata, w_sel_ram_wd, w_ram_rd, w_ram_wr,
            w_ram_ben, w_ram_wdata, w_rf_waddr, w_alu_result, w_pc} = r_em_bus;

    assign w_memop      = w_ram_rd | w_ram_wr;
    assign w_in_memop   = EX_to_MEM_bus[106] | EX_to_MEM_bus[105];
    assign w_ready_go   = ~w_memop
                        | ((r_state == S_WAIT) & data_ram_data_ok)
                        | (r_state == S_DONE);
    assign MEM_allow_in = ~r_mem_valid | (w_ready_go & WB_allow_in);
    assign w_accept     = EX_to_MEM_valid & MEM_allow_in;
    // A memop arriving in the same cycle the current one retires goes straight to REQ.
    assign w_next_memop = w_accept & w_in_memop;

    // Valid bit tracks the upstream handshake whenever this stage can take a new slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
        end else if (MEM_allow_in) begin
            r_mem_valid <= EX_to_MEM_valid;
        end
    end

    // Instruction payload captured on a successful EX->MEM transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_em_bus <= {EM_BUS_WD{1'b0}};
        end else if (w_accept) begin
            r_em_bus <= EX_to_MEM_bus;
        end
    end

    // Load data held while WB stalls after the response has already arrived.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata_buf <= 32'h0000_0000;
        end else if ((r_state == S_WAIT) && data_ram_data_ok && !WB_allow_in) begin
            r_rdata_buf <= data_ram_rdata;
        end
    end

    // RAM transaction state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RAM transaction next-state logic; data_ok outside WAIT is deliberately ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_next_memop) w_state_nxt = S_REQ;
                else              w_state_nxt = S_IDLE;
            end
            S_REQ: begin
                if (data_ram_addr_ok) w_state_nxt = S_WAIT;
                else                  w_state_nxt = S_REQ;
            end
            S_WAIT: begin
                if (data_ram_data_ok) begin
                    if (WB_allow_in) w_state_nxt = w_next_memop ? S_REQ : S_IDLE;
                    else             w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                if (WB_allow_in) w_state_nxt = w_next_memop ? S_REQ : S_IDLE;
                else             w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Raw load data forwarded to WB: live response in WAIT, buffered copy in DONE.
    always_comb begin
        w_wb_rdata = 32'h0000_0000;
        case (r_state)
            S_WAIT:  w_wb_rdata = data_ram_rdata;
            S_DONE:  w_wb_rdata = r_rdata_buf;
            default: w_wb_rdata = 32'h0000_0000;
        endcase
        if (!w_memop) begin
            w_wb_rdata = 32'h0000_0000;
        end else begin
            w_wb_rdata = w_wb_rdata;
        end
    end

    assign data_ram_req   = (r_state == S_REQ);
    assign data_ram_wr    = w_ram_wr;
    assign data_ram_wstrb = w_ram_wr ? w_ram_ben : 4'b0000;
    assign data_ram_addr  = w_alu_result;
    assign data_ram_wdata = w_ram_wdata;

    assign MEM_to_WB_valid = r_mem_valid & w_ready_go;
    assign MEM_to_WB_bus   = {w_stage, w_rf_we, w_sel_rf_wdata, w_sel_ram_wd, w_ram_ben,
                              w_wb_rdata, w_rf_waddr, w_alu_result, w_pc};

    // Bypass carries the ALU result only; a result produced in MEM is usable once ready.
    assign w_data_valid  = r_mem_valid & (w_stage[0] | (w_stage[1] & w_ready_go));
    assign MEM_to_BY_bus = {w_rf_waddr, w_alu_result, w_data_valid, r_mem_valid, w_rf_we};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads, WB stall,
// store, back-to-back loads and reset during an outstanding transaction.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         EX_to_MEM_valid;
    logic         MEM_allow_in;
    logic [112:0] EX_to_MEM_bus;
    logic         MEM_to_WB_valid;
    logic         WB_allow_in;
    logic [110:0] MEM_to_WB_bus;
    logic [39:0]  MEM_to_BY_bus;
    logic         data_ram_req;
    logic         data_ram_wr;
    logic [3:0]   data_ram_wstrb;
    logic [31:0]  data_ram_addr;
    logic [31:0]  data_ram_wdata;
    logic         data_ram_addr_ok;
    logic         data_ram_data_ok;
    logic [31:0]  data_ram_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .EX_to_MEM_valid (EX_to_MEM_valid),
        .MEM_allow_in    (MEM_allow_in),
        .EX_to_MEM_bus   (EX_to_MEM_bus),
        .MEM_to_WB_valid (MEM_to_WB_valid),
        .WB_allow_in     (WB_allow_in),
        .MEM_to_WB_bus   (MEM_to_WB_bus),
        .MEM_to_BY_bus   (MEM_to_BY_bus),
        .data_ram_req    (data_ram_req),
        .data_ram_wr     (data_ram_wr),
        .data_ram_wstrb  (data_ram_wstrb),
        .data_ram_addr   (data_ram_addr),
        .data_ram_wdata  (data_ram_wdata),
        .data_ram_addr_ok(data_ram_addr_ok),
        .data_ram_data_ok(data_ram_data_ok),
        .data_ram_rdata  (data_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [112:0] mk_em(input logic [2:0] stage, input logic rf_we,
        input logic sel_rf, input logic sel_ram, input logic rd, input logic wr,
        input logic [3:0] ben, input logic [31:0] wdata, input logic [4:0] waddr,
        input logic [31:0] alu, input logic [31:0] pc);
        return {stage, rf_we, sel_rf, sel_ram, rd, wr, ben, wdata, waddr, alu, pc};
    endfunction

    function automatic logic [110:0] mk_mw(input logic [2:0] stage, input logic rf_we,
        input logic sel_rf, input logic sel_ram, input logic [3:0] ben,
        input logic [31:0] rdata, input logic [4:0] waddr, input logic [31:0] alu,
        input logic [31:0] pc);
        return {stage, rf_we, sel_rf, sel_ram, ben, rdata, waddr, alu, pc};
    endfunction

    function automatic logic [39:0] mk_by(input logic [4:0] waddr, input logic [31:0] alu,
        input logic dv, input logic mv, input logic we);
        return {waddr, alu, dv, mv, we};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn           = 1'b0;
        EX_to_MEM_valid  = 1'b0;
        EX_to_MEM_bus    = '0;
        WB_allow_in      = 1'b1;
        data_ram_addr_ok = 1'b0;
        data_ram_data_ok = 1'b0;
        data_ram_rdata   = 32'h0;

        // Reset state
        smp();
        chk("rst_wb_valid", 128'(MEM_to_WB_valid), 128'd0);
        chk("rst_req",      128'(data_ram_req),    128'd0);
        chk("rst_wstrb",    128'(data_ram_wstrb),  128'd0);
        chk("rst_wb_bus",   128'(MEM_to_WB_bus),   128'd0);
        chk("rst_by_bus",   128'(MEM_to_BY_bus),   128'd0);
        chk("rst_allow_in", 128'(MEM_allow_in),    128'd1);
        nxt();
        resetn = 1'b1;
        nxt();

        // ALU instruction passes through in one cycle
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk_em(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,
                                5'd5, 32'h0000_1234, 32'h0000_1000);
        smp();
        chk("alu_allow_in", 128'(MEM_allow_in), 128'd1);
        nxt();
        EX_to_MEM_valid = 1'b0;
        smp();
        chk("alu_wb_valid", 128'(MEM_to_WB_valid), 128'd1);
        chk("alu_req",      128'(data_ram_req),    128'd0);
        chk("alu_wb_alu",   128'(MEM_to_WB_bus[63:32]), 128'h1234);
        chk("alu_wb_bus",   128'(MEM_to_WB_bus),
            128'(mk_mw(3'b001, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 5'd5, 32'h1234, 32'h1000)));
        chk("alu_by_bus",   128'(MEM_to_BY_bus), 128'(mk_by(5'd5, 32'h1234, 1'b1, 1'b1, 1'b1)));
        nxt();
        smp();
        chk("alu_gone", 128'(MEM_to_WB_valid), 128'd0);
        nxt();

        // Load, addr_ok after 2 wait cycles, data_ok the cycle after
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk_em(3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 32'h0,
                                5'd7, 32'h0000_0100, 32'h0000_1004);
        nxt();
        EX_to_MEM_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_ram_addr_ok = (i == 2) ? 1'b1 : 1'b0;
            smp();
            chk("ld_req",      128'(data_ram_req),    128'd1);
            chk("ld_addr",     128'(data_ram_addr),   128'h100);
            chk("ld_wr",       128'(data_ram_wr),     128'd0);
            chk("ld_wstrb",    128'(data_ram_wstrb),  128'd0);
            chk("ld_allow_in", 128'(MEM_allow_in),    128'd0);
            chk("ld_wb_valid", 128'(MEM_to_WB_valid), 128'd0);
            nxt();
        end
        data_ram_addr_ok = 1'b0;
        data_ram_data_ok = 1'b1;
        data_ram_rdata   = 32'hDEAD_BEEF;
        smp();
        chk("ld_req_off",  128'(data_ram_req),    128'd0);
        chk("ld_valid",    128'(MEM_to_WB_valid), 128'd1);
        chk("ld_allow_dk", 128'(MEM_allow_in),    128'd1);
        chk("ld_wb_bus",   128'(MEM_to_WB_bus),
            128'(mk_mw(3'b100, 1'b1, 1'b1, 1'b1, 4'b0001, 32'hDEADBEEF, 5'd7, 32'h100, 32'h1004)));
        chk("ld_by_bus",   128'(MEM_to_BY_bus), 128'(mk_by(5'd7, 32'h100, 1'b0, 1'b1, 1'b1)));
        nxt();
        data_ram_data_ok = 1'b0;
        data_ram_rdata   = 32'h0;
        smp();
        chk("ld_gone",  128'(MEM_to_WB_valid), 128'd0);
        chk("ld_idle",  128'(data_ram_req),    128'd0);
        chk("ld_allow", 128'(MEM_allow_in),    128'd1);
        nxt();

        // Load with WB stalled for 3 cycles after data_ok
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk_em(3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 32'h0,
                                5'd9, 32'h0000_0100, 32'h0000_1008);
        nxt();
        EX_to_MEM_valid  = 1'b0;
        data_ram_addr_ok = 1'b1;
        smp();
        chk("st_req",   128'(data_ram_req), 128'd1);
        chk("st_by_rq", 128'(MEM_to_BY_bus), 128'(mk_by(5'd9, 32'h100, 1'b0, 1'b1, 1'b1)));
        nxt();
        data_ram_addr_ok = 1'b0;
        data_ram_data_ok = 1'b1;
        data_ram_rdata   = 32'hDEAD_BEEF;
        WB_allow_in      = 1'b0;
        smp();
        chk("st_valid_dk", 128'(MEM_to_WB_valid), 128'd1);
        chk("st_allow_dk", 128'(MEM_allow_in),    128'd0);
        nxt();
        data_ram_data_ok = 1'b0;
        data_ram_rdata   = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            WB_allow_in = (i == 2) ? 1'b1 : 1'b0;
            if (i == 2) data_ram_rdata = 32'h2222_2222;
            smp();
            chk("st_hold_valid", 128'(MEM_to_WB_valid), 128'd1);
            chk("st_hold_bus",   128'(MEM_to_WB_bus),
                128'(mk_mw(3'b010, 1'b1, 1'b1, 1'b1, 4'b0001, 32'hDEADBEEF, 5'd9, 32'h100, 32'h1008)));
            chk("st_hold_req",   128'(data_ram_req), 128'd0);
            chk("st_hold_by",    128'(MEM_to_BY_bus), 128'(mk_by(5'd9, 32'h100, 1'b1, 1'b1, 1'b1)));
            chk("st_hold_allow", 128'(MEM_allow_in), (i == 2) ? 128'd1 : 128'd0);
            nxt();
        end
        WB_allow_in    = 1'b1;
        data_ram_rdata = 32'h0;
        smp();
        chk("st_gone", 128'(MEM_to_WB_valid), 128'd0);
        nxt();

        // Store, byte strobes 1100
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk_em(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 32'hAABB_CCDD,
                                5'd0, 32'h0000_0200, 32'h0000_100C);
        nxt();
        EX_to_MEM_valid  = 1'b0;
        data_ram_addr_ok = 1'b1;
        smp();
        chk("sw_req",   128'(data_ram_req),   128'd1);
        chk("sw_wr",    128'(data_ram_wr),    128'd1);
        chk("sw_wstrb", 128'(data_ram_wstrb), 128'b1100);
        chk("sw_wdata", 128'(data_ram_wdata), 128'hAABBCCDD);
        chk("sw_addr",  128'(data_ram_addr),  128'h200);
        nxt();
        data_ram_addr_ok = 1'b0;
        data_ram_data_ok = 1'b1;
        smp();
        chk("sw_valid", 128'(MEM_to_WB_valid), 128'd1);
        chk("sw_rf_we", 128'(MEM_to_WB_bus[107]), 128'd0);
        chk("sw_wb_bus", 128'(MEM_to_WB_bus),
            128'(mk_mw(3'b000, 1'b0, 1'b0, 1'b0, 4'b1100, 32'h0, 5'd0, 32'h200, 32'h100C)));
        nxt();
        data_ram_data_ok = 1'b0;
        smp();
        chk("sw_gone", 128'(MEM_to_WB_valid), 128'd0);
        chk("sw_req0", 128'(data_ram_req),    128'd0);
        nxt();

        // Two back-to-back loads
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk_em(3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h0,
                                5'd10, 32'h0000_0300, 32'h0000_2000);
        nxt();
        EX_to_MEM_bus    = mk_em(3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h0,
                                 5'd11, 32'h0000_0304, 32'h0000_2004);
        data_ram_addr_ok = 1'b1;
        smp();
        chk("bb_allow0", 128'(MEM_allow_in),  128'd0);
        chk("bb_req_a",  128'(data_ram_req),  128'd1);
        chk("bb_addr_a", 128'(data_ram_addr), 128'h300);
        nxt();
        data_ram_addr_ok = 1'b0;
        data_ram_data_ok = 1'b1;
        data_ram_rdata   = 32'h0102_0304;
        smp();
        chk("bb_valid_a", 128'(MEM_to_WB_valid), 128'd1);
        chk("bb_allow_a", 128'(MEM_allow_in),    128'd1);
        chk("bb_no_req",  128'(data_ram_req),    128'd0);
        chk("bb_rdata_a", 128'(MEM_to_WB_bus[100:69]), 128'h01020304);
        nxt();
        EX_to_MEM_valid  = 1'b0;
        data_ram_data_ok = 1'b0;
        data_ram_rdata   = 32'h0;
        smp();
        chk("bb_req_b",   128'(data_ram_req),    128'd1);
        chk("bb_addr_b",  128'(data_ram_addr),   128'h304);
        chk("bb_valid_0", 128'(MEM_to_WB_valid), 128'd0);
        nxt();
        data_ram_addr_ok = 1'b1;
        smp();
        chk("bb_req_b2", 128'(data_ram_req), 128'd1);
        nxt();
        data_ram_addr_ok = 1'b0;
        data_ram_data_ok = 1'b1;
        data_ram_rdata   = 32'h0506_0708;
        smp();
        chk("bb_valid_b", 128'(MEM_to_WB_valid), 128'd1);
        chk("bb_wb_bus_b", 128'(MEM_to_WB_bus),
            128'(mk_mw(3'b100, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h05060708, 5'd11, 32'h304, 32'h2004)));
        nxt();
        data_ram_data_ok = 1'b0;
        data_ram_rdata   = 32'h0;
        smp();
        chk("bb_gone", 128'(MEM_to_WB_valid), 128'd0);
        chk("bb_req0", 128'(data_ram_req),    128'd0);
        nxt();

        // Reset while waiting for data_ok, then a stale response
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk_em(3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 32'h0,
                                5'd12, 32'h0000_0400, 32'h0000_3000);
        nxt();
        EX_to_MEM_valid  = 1'b0;
        data_ram_addr_ok = 1'b1;
        nxt();
        data_ram_addr_ok = 1'b0;
        resetn           = 1'b0;
        smp();
        chk("rw_valid", 128'(MEM_to_WB_valid), 128'd0);
        chk("rw_req",   128'(data_ram_req),    128'd0);
        chk("rw_allow", 128'(MEM_allow_in),    128'd1);
        chk("rw_bus",   128'(MEM_to_WB_bus),   128'd0);
        nxt();
        resetn           = 1'b1;
        data_ram_data_ok = 1'b1;
        data_ram_rdata   = 32'hCAFE_F00D;
        smp();
        chk("rw_stale_valid", 128'(MEM_to_WB_valid), 128'd0);
        chk("rw_stale_req",   128'(data_ram_req),    128'd0);
        chk("rw_stale_bus",   128'(MEM_to_WB_bus),   128'd0);
        nxt();
        data_ram_data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("rw_idle_req",   128'(data_ram_req),    128'd0);
            chk("rw_idle_valid", 128'(MEM_to_WB_valid), 128'd0);
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
